int_to_fp: RTL and testbench
============================

INT_TO_FP -- requirements
Module: int_to_fp

Interface
REQ-001 SHALL have no parameters; all widths are fixed constants from int_to_fp_pkg.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  int_in holds a sample to convert this cycle.
REQ-005 int_in  input  8  two's-complement signed integer, range -128..127.
REQ-006 out_valid  output  1  fp holds a new conversion result.
REQ-007 fp  output  13  result {sign[12], exp[11:8], frac[7:0]}.

Function
REQ-008 fp value SHALL equal (-1)^sign × 0.frac × 2^exp, with frac as an unsigned binary fraction.
REQ-009 sign SHALL equal int_in[7].
REQ-010 magnitude m SHALL be |int_in| computed in 8 unsigned bits; -128 yields m = 128 with no overflow.
REQ-011 For m ≠ 0:
- exp SHALL be the 1-based position of the leading one of m (1..8).
- frac SHALL be m left-shifted until frac[7] = 1, zero-filled.
- The conversion is exact, with no rounding.
REQ-012 int_in = 0 SHALL give fp = 13'h0000 (sign 0, exp 0, frac 0); no negative zero exists.
REQ-013 Latency SHALL be exactly 1 clk:
- int_in sampled with in_valid = 1 at edge N appears on fp with out_valid = 1 after edge N.
- Full throughput: a new sample is accepted every cycle.
- There is no backpressure.
REQ-014 When in_valid = 0 at an edge:
- out_valid SHALL go 0 after that edge.
- fp SHALL hold its previous value.
REQ-015 fp and out_valid SHALL be driven directly from flip-flops, with no combinational path from inputs to outputs.
REQ-016 Normalization SHALL be a priority leading-one detect plus left shift of 0..7 places; no loops with data-dependent bounds.

Reset
REQ-017 While reset = 1, fp SHALL be 13'h0000 and out_valid SHALL be 0, independent of clk.
REQ-018 Reset asserted mid-stream SHALL discard the in-flight sample.
REQ-019 After reset deasserts, the first edge with in_valid = 1 SHALL produce a valid result one cycle later.

Structure
REQ-020 Package int_to_fp_pkg SHALL hold:
- INT_W = 8, EXP_W = 4, FRAC_W = 8, FP_W = 13;
- FP_ZERO = 13'h0000;
- a packed fp struct type {sign, exp, frac}.
REQ-021 One sub-module, int_to_fp_norm, SHALL be purely combinational. It takes an 8-bit unsigned magnitude and returns exp[3:0] and frac[7:0], with zero detection. The top level holds the sign/abs logic and the output registers.

Verification
REQ-022 The bench SHALL cover the directed scenarios below. Each input is applied with in_valid = 1; fp is checked one cycle later.

| Stimulus | Required fp | Note |
|---|---|---|
| int_in = 0 | 13'h0000 | out_valid = 1 |
| int_in = 1 | 13'h0180 | |
| int_in = 127 | 13'h07FE | exp 7, frac 1111_1110 |
| int_in = 8'hFF (-1) | 13'h1180 | |
| int_in = 8'h80 (-128) | 13'h1880 | |

REQ-023 Full sweep: int_in stepping 0..255 on consecutive cycles, with in_valid held 1. Every output SHALL match the reference model of REQ-008..012. out_valid SHALL stay 1 with no gaps.
REQ-024 Hold: in_valid dropped for 3 cycles. out_valid SHALL be 0 and fp SHALL stay unchanged.
REQ-025 Reset mid-stream: reset pulsed between edges. fp SHALL be 0 and out_valid SHALL be 0 immediately. Conversion SHALL resume correctly after release.

Source files
------------

// File: rtl/int_to_fp_pkg.sv
// Shared widths, the zero constant and the packed floating-point layout
// for the 8-bit integer to 13-bit float converter.
package int_to_fp_pkg;

  localparam int INT_W  = 8;
  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;
  localparam int FP_W   = 13;

  localparam logic [FP_W-1:0] FP_ZERO = 13'h0000;

  // Value is (-1)^sign * 0.frac * 2^exp, frac is an unsigned fraction.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

endpackage

// File: rtl/int_to_fp_norm.sv
// Combinational normaliser: finds the leading one of an unsigned magnitude,
// shifts it up to the top fraction bit and reports the matching exponent.
module int_to_fp_norm
  import int_to_fp_pkg::*;
(
  input  logic [INT_W-1:0]  mag_i,
  output logic [EXP_W-1:0]  exp_o,
  output logic [FRAC_W-1:0] frac_o,
  output logic              zero_o
);

  logic [2:0] shiftAmt;

  // Priority leading-one detect; the highest set bit wins and sets the shift.
  always_comb begin
    shiftAmt = 3'd0;
    zero_o   = 1'b0;
    if (mag_i[7])      shiftAmt = 3'd0;
    else if (mag_i[6]) shiftAmt = 3'd1;
    else if (mag_i[5]) shiftAmt = 3'd2;
    else if (mag_i[4]) shiftAmt = 3'd3;
    else if (mag_i[3]) shiftAmt = 3'd4;
    else if (mag_i[2]) shiftAmt = 3'd5;
    else if (mag_i[1]) shiftAmt = 3'd6;
    else if (mag_i[0]) shiftAmt = 3'd7;
    else               zero_o   = 1'b1;
  end

  // Zero has no leading one, so it is forced to exp 0 and frac 0 explicitly.
  always_comb begin
    exp_o  = '0;
    frac_o = '0;
    if (!zero_o) begin
      exp_o  = 4'd8 - {1'b0, shiftAmt};
      frac_o = mag_i << shiftAmt;
    end
  end

endmodule

// File: rtl/int_to_fp.sv
// Top level: takes the sign and magnitude of a signed 8-bit sample, normalises
// the magnitude and registers the float result with one cycle of latency.
module int_to_fp
  import int_to_fp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [INT_W-1:0] int_in,
  output logic             out_valid,
  output logic [FP_W-1:0]  fp
);

  logic              sign;
  logic [INT_W-1:0]  mag;
  logic [EXP_W-1:0]  normExp;
  logic [FRAC_W-1:0] normFrac;
  logic              normZero;
  fp_t               fp_d, fp_q;
  logic              out_valid_d, out_valid_q;

  // Sign is the MSB; the 8-bit two's-complement negate maps -128 onto 128.
  always_comb begin
    sign = int_in[INT_W-1];
    mag  = sign ? (~int_in + 8'd1) : int_in;
  end

  int_to_fp_norm u_norm (
    .mag_i  (mag),
    .exp_o  (normExp),
    .frac_o (normFrac),
    .zero_o (normZero)
  );

  // New result on a valid sample, otherwise hold the last result.
  always_comb begin
    fp_d        = fp_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      fp_d.sign = sign & ~normZero;
      fp_d.exp  = normExp;
      fp_d.frac = normFrac;
    end
  end

  // Output registers; reset clears them at once and drops any in-flight sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fp_q        <= FP_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      fp_q        <= fp_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fp        = fp_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_int_to_fp.sv
// Directed bench for int_to_fp: table vectors, full input sweep against a
// reference model, hold behaviour and reset in the middle of a stream.
module tb_int_to_fp;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  int_in;
  logic        out_valid;
  logic [12:0] fp;

  int checkCount = 0;
  int failCount  = 0;

  int_to_fp dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .int_in    (int_in),
    .out_valid (out_valid),
    .fp        (fp)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one input at the falling edge, then sample just after the next rise.
  task automatic applyStimulus(input logic valid, input logic [7:0] value);
    @(negedge clk);
    in_valid = valid;
    int_in   = value;
    @(posedge clk);
    #1;
  endtask

  // Reference: normalise by repeated doubling, counting the exponent down.
  function automatic logic [12:0] refModel(input logic [7:0] v);
    logic       s;
    logic [7:0] m;
    logic [3:0] e;
    s = v[7];
    m = s ? 8'(-v) : v;
    if (m == 8'd0) return 13'h0000;
    e = 4'd8;
    repeat (7) begin
      if (!m[7]) begin
        m = m << 1;
        e = e - 4'd1;
      end
    end
    return {s, e, m};
  endfunction

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    int_in   = 8'h00;
    #1;
    checkOutput("reset_fp", 16'(fp), 16'h0000);
    checkOutput("reset_valid", 16'(out_valid), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table vectors with hand-computed results.
    applyStimulus(1'b1, 8'd0);
    checkOutput("vec_zero", 16'(fp), 16'h0000);
    checkOutput("vec_zero_valid", 16'(out_valid), 16'h0001);
    applyStimulus(1'b1, 8'd1);
    checkOutput("vec_one", 16'(fp), 16'h0180);
    applyStimulus(1'b1, 8'd127);
    checkOutput("vec_127", 16'(fp), 16'h07FE);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("vec_m1", 16'(fp), 16'h1180);
    applyStimulus(1'b1, 8'h80);
    checkOutput("vec_m128", 16'(fp), 16'h1880);
    applyStimulus(1'b1, 8'd5);
    checkOutput("vec_5", 16'(fp), 16'h03A0);
    applyStimulus(1'b1, 8'd96);
    checkOutput("vec_96", 16'(fp), 16'h07C0);

    // Full sweep on consecutive cycles.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 8'(i));
      checkOutput($sformatf("sweep_%0d", i), 16'(fp), 16'(refModel(8'(i))));
      checkOutput($sformatf("sweep_valid_%0d", i), 16'(out_valid), 16'h0001);
    end

    // Hold: last result must persist while in_valid is low.
    applyStimulus(1'b1, 8'hFB);
    checkOutput("hold_load", 16'(fp), 16'h13A0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'(8'h11 * (i + 1)));
      checkOutput($sformatf("hold_fp_%0d", i), 16'(fp), 16'h13A0);
      checkOutput($sformatf("hold_valid_%0d", i), 16'(out_valid), 16'h0000);
    end

    // Reset between edges while a sample is pending.
    applyStimulus(1'b1, 8'd127);
    checkOutput("rst_pre", 16'(fp), 16'h07FE);
    @(negedge clk);
    in_valid = 1'b1;
    int_in   = 8'hFF;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_fp", 16'(fp), 16'h0000);
    checkOutput("rst_async_valid", 16'(out_valid), 16'h0000);
    @(posedge clk);
    #1;
    checkOutput("rst_discard_fp", 16'(fp), 16'h0000);
    checkOutput("rst_discard_valid", 16'(out_valid), 16'h0000);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_idle_valid", 16'(out_valid), 16'h0000);
    applyStimulus(1'b1, 8'd5);
    checkOutput("rst_resume_fp", 16'(fp), 16'h03A0);
    checkOutput("rst_resume_valid", 16'(out_valid), 16'h0001);
    applyStimulus(1'b1, 8'h80);
    checkOutput("rst_resume_m128", 16'(fp), 16'h1880);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
